// File: rtl/estado_mascota.sv
// Pet mood classifier: filters level combinations into a stable mood,
// escalates a long-critical pet to sick, and offers a code-stepping test mode.
module estado_mascota #(
    parameter int CLK_FREQ       = 50000000,
    parameter int ESTABLE_CICLOS = 16,
    parameter int ENFERMO_SEG    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] nivel_hambre,
    input  logic [2:0] nivel_diversion,
    input  logic       test,
    output logic [2:0] estado,
    output logic       alarma,
    output logic       cambio,
    output logic       en_test
);
    localparam logic [2:0] FELIZ      = 3'd0;
    localparam logic [2:0] NEUTRO     = 3'd1;
    localparam logic [2:0] HAMBRIENTO = 3'd2;
    localparam logic [2:0] ABURRIDO   = 3'd3;
    localparam logic [2:0] CRITICO    = 3'd4;
    localparam logic [2:0] ENFERMO    = 3'd5;

    localparam int PW = $clog2(CLK_FREQ + 1);
    localparam int FW = $clog2(ESTABLE_CICLOS + 1);
    localparam int SW = $clog2(ENFERMO_SEG + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam logic [FW-1:0] FILT_MAX  = FW'(ESTABLE_CICLOS);
    localparam logic [SW-1:0] SICK_MAX  = SW'(ENFERMO_SEG);

    logic [2:0]    h, d;
    logic [2:0]    cand, cand_q;
    logic [2:0]    mood, mood_next;
    logic [FW-1:0] filt_cnt, filt_next, run;
    logic [SW-1:0] sick_cnt, sick_next;
    logic [PW-1:0] presc;
    logic          tick;
    logic          aceptable, critico;
    logic          test_q, flanco;
    logic [2:0]    codigo;
    logic          parpadeo;
    logic [2:0]    estado_q;

    // Clamp raw levels into the legal 1..5 range
    always_comb begin
        h = nivel_hambre;
        d = nivel_diversion;
        if (h == 3'd0) h = 3'd1;
        else if (h > 3'd5) h = 3'd5;
        if (d == 3'd0) d = 3'd1;
        else if (d > 3'd5) d = 3'd5;
    end

    // Candidate mood, first matching rule wins
    always_comb begin
        cand = NEUTRO;
        if (h >= 3'd4 && d <= 3'd2) cand = CRITICO;
        else if (h >= 3'd4) cand = HAMBRIENTO;
        else if (d <= 3'd2) cand = ABURRIDO;
        else if (h <= 3'd2 && d >= 3'd4) cand = FELIZ;
    end

    assign tick    = (presc == PRESC_MAX);
    assign flanco  = test & ~test_q;
    assign critico = (mood == CRITICO) && (h == 3'd5) && (d == 3'd1);

    // Free-running one-second prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) presc <= '0;
        else if (tick) presc <= '0;
        else presc <= presc + PW'(1);
    end

    // Mood register, filter and sick counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mood     <= FELIZ;
            cand_q   <= FELIZ;
            filt_cnt <= '0;
            sick_cnt <= '0;
        end else begin
            mood     <= mood_next;
            cand_q   <= cand;
            filt_cnt <= filt_next;
            sick_cnt <= sick_next;
        end
    end

    // Next mood: stability filter, then sick escalation overriding it
    always_comb begin
        mood_next = mood;
        filt_next = '0;
        sick_next = '0;
        run       = (cand == cand_q) ? filt_cnt + FW'(1) : FW'(1);
        aceptable = (cand != mood) &&
                    (mood != ENFERMO || cand == FELIZ || cand == NEUTRO);
        if (aceptable) begin
            if (run == FILT_MAX) mood_next = cand;
            else filt_next = run;
        end
        if (critico) begin
            if (tick) begin
                if (sick_cnt + SW'(1) == SICK_MAX) begin
                    mood_next = ENFERMO;
                    filt_next = '0;
                end else begin
                    sick_next = sick_cnt + SW'(1);
                end
            end else begin
                sick_next = sick_cnt;
            end
        end
    end

    // Test mode: each rising edge of the button steps the shown code
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            test_q  <= 1'b0;
            en_test <= 1'b0;
            codigo  <= 3'd0;
        end else begin
            test_q <= test;
            if (flanco) begin
                if (!en_test) begin
                    en_test <= 1'b1;
                    codigo  <= 3'd0;
                end else if (codigo == 3'd5) begin
                    en_test <= 1'b0;
                end else begin
                    codigo <= codigo + 3'd1;
                end
            end
        end
    end

    // Blink phase for the sick alarm, restarted high when code 5 appears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parpadeo <= 1'b0;
        else if (mood_next == ENFERMO && mood != ENFERMO) parpadeo <= 1'b1;
        else if (flanco && en_test && codigo == 3'd4 && mood != ENFERMO)
            parpadeo <= 1'b1;
        else if (tick) parpadeo <= ~parpadeo;
    end

    // Shown code and alarm follow the test code while test mode is active
    always_comb begin
        estado = en_test ? codigo : mood;
        alarma = (estado == CRITICO) || (estado == ENFERMO && parpadeo);
    end

    // Change pulse one cycle after the shown code moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= FELIZ;
            cambio   <= 1'b0;
        end else begin
            estado_q <= estado;
            cambio   <= (estado != estado_q);
        end
    end
endmodule
